simd_mem_arbiter: RTL and testbench
===================================

Name: simd_mem_arbiter

Overview:
- Shares the single 32-bit data-memory port between the scalar pipeline's memory stage (32-bit word) and the vector pipeline's memory stage (256-bit, 8 lanes).
- Serialises each vector access into LANES word beats and assembles or scatters the lanes.
- Stalls both pipelines while any access is outstanding.
- Sits between the Memory stage and the shared synchronous data RAM, which has 1-cycle read latency.

Parameters:
- ADDR_W, 32, byte-address width.
- LANE_W, 32, bits per vector lane and per RAM word.
- LANES, 8, lanes per vector; the vector width is LANES*LANE_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- s_req  in  1  scalar access request; held high until s_ready.
- s_we  in  1  scalar write (1) or read (0).
- s_addr  in  ADDR_W  scalar byte address.
- s_wdata  in  LANE_W  scalar write data.
- s_rdata  out  LANE_W  scalar read data; registered and held.
- s_ready  out  1  one-cycle completion pulse.
- v_req  in  1  vector access request; held high until v_ready.
- v_we  in  1  vector write (1) or read (0).
- v_addr  in  ADDR_W  vector base byte address.
- v_wdata  in  LANES*LANE_W  vector write data; lane i occupies [LANE_W*i +: LANE_W].
- v_rdata  out  LANES*LANE_W  vector read data; registered and held.
- v_ready  out  1  one-cycle completion pulse.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM byte address; bits [1:0] are always 0.
- mem_wdata  out  LANE_W  RAM write data.
- mem_rdata  in  LANE_W  RAM read data; valid the cycle after its address is presented.
- stall  out  1  = (s_req & ~s_ready) | (v_req & ~v_ready); combinational.

Behaviour:
- Reset (synchronous, applied on any clk edge with reset=1):
  - state=IDLE, last_grant=VEC, beat and capture counters=0.
  - s_rdata=0, v_rdata=0, s_ready=0, v_ready=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - A reset mid-burst abandons the burst; no further RAM writes occur after the reset edge.
- States: IDLE, S_ISSUE, S_WAIT, S_RESP, V_BURST, V_WAIT, V_RESP.
- IDLE:
  - Only s_req set: grant scalar. Only v_req set: grant vector.
  - Both set: grant the requester opposite to last_grant (round-robin), then update last_grant.
  - At the grant edge, latch we, addr (bits [1:0] cleared) and wdata of the winner. Later input changes are ignored until the response completes.
- Scalar access:
  - S_ISSUE drives mem_addr=latched addr, mem_we=latched we, mem_wdata=latched data.
  - Write: next state S_RESP.
  - Read: next state S_WAIT. In S_WAIT, mem_rdata is loaded into s_rdata at the cycle-end edge, then S_RESP.
  - S_RESP: s_ready=1 for exactly one cycle, then IDLE.
  - Latency from the grant edge: write ready 2 cycles later, read ready 3 cycles later.
- Vector access:
  - V_BURST lasts LANES cycles. Beat b (0..LANES-1) drives mem_addr = base + 4*b (mod 2^ADDR_W) and mem_wdata = lane b.
  - Read: the capture counter trails the beat counter by one. mem_rdata during beat b+1 (or during V_WAIT for the last lane) is loaded into lane b of v_rdata.
  - Write: after the last beat go to V_RESP. Read: after the last beat go to V_WAIT (last-lane capture), then V_RESP.
  - V_RESP: v_ready=1 for one cycle, then IDLE.
  - Latency: write 9 cycles, read 10 cycles (LANES=8).
- RAM port idle value: in IDLE, S_WAIT, S_RESP, V_WAIT and V_RESP, mem_we=0, mem_addr=0 and mem_wdata=0.
- RESP back-to-back: a request still high in the cycle after its RESP is a new access and is arbitrated in IDLE. The minimum gap between grants is therefore 1 IDLE cycle.
- Held outputs: v_rdata changes only on vector read captures; s_rdata changes only in S_WAIT. A write never alters either.
- Stall: stall stays high through the whole access; it drops in the RESP cycle for the serviced requester only.

Decomposition:
- Package simd_mem_pkg: state_t enum, grant_t {SCALAR, VEC}, constants LANES, LANE_W, BYTES_PER_WORD=4.
- One sub-module rr_arb2: a 2-requester round-robin picker with a last_grant register (clk, reset, req[1:0] -> gnt[1:0], update-on-grant).

Test Plan:
- Scalar write then read: s_we=1, addr 0x10, data 0xDEADBEEF -> mem_we=1 at addr 0x10 for one cycle, s_ready 2 cycles after grant. Read of 0x10 -> s_rdata=0xDEADBEEF with s_ready 3 cycles after grant.
- Vector write, base 0x100, lane i = 0x1000+i -> 8 consecutive writes at 0x100..0x11C with the matching data, v_ready 9 cycles after grant. Vector read of 0x100 -> v_rdata lanes 0x1000..0x1007, v_ready 10 cycles after grant.
- Simultaneous s_req and v_req right after reset -> scalar granted first (last_grant=VEC), vector next. Requests held continuously -> grants alternate S, V, S, V; stall stays high for the waiting requester.
- Wrap-around: vector write, base 0xFFFFFFF8 -> beat addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 ... 0x14. Misaligned s_addr 0x13 -> mem_addr 0x10.
- Reset asserted during beat 3 of a vector write -> next cycle mem_we=0, all outputs 0, state IDLE. Lanes 4..7 are never written.
- Inputs changed mid-access: v_addr altered during V_BURST -> beat addresses still follow the latched base. s_rdata is unchanged by an intervening vector access.

Source files
------------

// File: rtl/simd_mem_pkg.sv
// Shared types and constants for the scalar/vector data-memory arbiter.
package simd_mem_pkg;
    localparam int LANES          = 8;
    localparam int LANE_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        V_BURST,
        V_WAIT,
        V_RESP
    } state_t;

    typedef enum logic {
        SCALAR = 1'b0,
        VEC    = 1'b1
    } grant_t;
endpackage

// File: rtl/simd_mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker; req[0] is scalar, req[1] is vector.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);
    import simd_mem_pkg::*;

    grant_t r_last_grant;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (r_last_grant == VEC) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= VEC;
        end else if (update && (gnt != 2'b00)) begin
            r_last_grant <= gnt[1] ? VEC : SCALAR;
        end
    end
endmodule

// File: rtl/simd_mem_arbiter.sv
// Shares one 32-bit synchronous data RAM port between the scalar and vector
// memory stages; vector accesses are serialised into LANES word beats.
module simd_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LANE_W = simd_mem_pkg::LANE_W,
    parameter int LANES  = simd_mem_pkg::LANES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_req,
    input  logic                    s_we,
    input  logic [ADDR_W-1:0]       s_addr,
    input  logic [LANE_W-1:0]       s_wdata,
    output logic [LANE_W-1:0]       s_rdata,
    output logic                    s_ready,
    input  logic                    v_req,
    input  logic                    v_we,
    input  logic [ADDR_W-1:0]       v_addr,
    input  logic [LANES*LANE_W-1:0] v_wdata,
    output logic [LANES*LANE_W-1:0] v_rdata,
    output logic                    v_ready,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [LANE_W-1:0]       mem_wdata,
    input  logic [LANE_W-1:0]       mem_rdata,
    output logic                    stall
);
    import simd_mem_pkg::*;

    localparam int VEC_W = LANES * LANE_W;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(BYTES_PER_WORD - 1);
    endfunction

    state_t              r_state;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [VEC_W-1:0]    r_vwdata;
    logic [CNT_W-1:0]    r_beat;
    logic [CNT_W-1:0]    r_cap;
    logic [LANE_W-1:0]   r_s_rdata;
    logic [VEC_W-1:0]    r_v_rdata;
    logic                r_s_ready;
    logic                r_v_ready;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [LANE_W-1:0]   r_mem_wdata;

    logic [1:0]          w_gnt;
    logic                w_arb_update;
    logic [CNT_W-1:0]    w_beat_nx;
    logic [ADDR_W-1:0]   w_beat_addr;
    logic                w_last_beat;

    assign w_arb_update = (r_state == IDLE);
    assign w_beat_nx    = r_beat + CNT_W'(1);
    assign w_beat_addr  = r_addr + (ADDR_W'(w_beat_nx) << 2);
    assign w_last_beat  = (r_beat == CNT_W'(LANES - 1));

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({v_req, s_req}),
        .update (w_arb_update),
        .gnt    (w_gnt)
    );

    // RAM port, ready pulses and read-data registers are all registered; the
    // port returns to zero in every state that is not actively issuing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_vwdata    <= '0;
            r_beat      <= '0;
            r_cap       <= '0;
            r_s_rdata   <= '0;
            r_v_rdata   <= '0;
            r_s_ready   <= 1'b0;
            r_v_ready   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_s_ready   <= 1'b0;
            r_v_ready   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            case (r_state)
                IDLE: begin
                    if (w_gnt[0]) begin
                        r_we        <= s_we;
                        r_addr      <= word_align(s_addr);
                        r_mem_we    <= s_we;
                        r_mem_addr  <= word_align(s_addr);
                        r_mem_wdata <= s_wdata;
                        r_state     <= S_ISSUE;
                    end else if (w_gnt[1]) begin
                        r_we        <= v_we;
                        r_addr      <= word_align(v_addr);
                        r_vwdata    <= v_wdata;
                        r_beat      <= '0;
                        r_cap       <= '0;
                        r_mem_we    <= v_we;
                        r_mem_addr  <= word_align(v_addr);
                        r_mem_wdata <= v_wdata[LANE_W-1:0];
                        r_state     <= V_BURST;
                    end
                end
                S_ISSUE: begin
                    if (r_we) begin
                        r_s_ready <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_s_rdata <= mem_rdata;
                    r_s_ready <= 1'b1;
                    r_state   <= S_RESP;
                end
                V_BURST: begin
                    // Read data for beat b arrives during beat b+1.
                    if (!r_we && (r_beat != '0)) begin
                        r_v_rdata[int'(r_cap)*LANE_W +: LANE_W] <= mem_rdata;
                        r_cap <= r_cap + CNT_W'(1);
                    end
                    if (w_last_beat) begin
                        if (r_we) begin
                            r_v_ready <= 1'b1;
                            r_state   <= V_RESP;
                        end else begin
                            r_state   <= V_WAIT;
                        end
                    end else begin
                        r_beat      <= w_beat_nx;
                        r_mem_we    <= r_we;
                        r_mem_addr  <= w_beat_addr;
                        r_mem_wdata <= r_vwdata[int'(w_beat_nx)*LANE_W +: LANE_W];
                    end
                end
                V_WAIT: begin
                    r_v_rdata[int'(r_cap)*LANE_W +: LANE_W] <= mem_rdata;
                    r_v_ready <= 1'b1;
                    r_state   <= V_RESP;
                end
                S_RESP, V_RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_rdata   = r_s_rdata;
    assign s_ready   = r_s_ready;
    assign v_rdata   = r_v_rdata;
    assign v_ready   = r_v_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign stall     = (s_req & ~r_s_ready) | (v_req & ~r_v_ready);
endmodule

// File: tb/tb_simd_mem_arbiter.sv
// Self-checking bench for simd_mem_arbiter with a 1-cycle-latency RAM model
// and a transaction-level reference model of memory contents and grants.
module tb_simd_mem_arbiter;
    localparam int LANES = 8;
    localparam int LW    = 32;
    localparam int VW    = LANES * LW;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_req, s_we, v_req, v_we;
    logic [31:0]   s_addr, s_wdata, v_addr;
    logic [VW-1:0] v_wdata;
    logic [31:0]   s_rdata;
    logic [VW-1:0] v_rdata;
    logic          s_ready, v_ready, mem_we, stall;
    logic [31:0]   mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    simd_mem_arbiter #(.ADDR_W(32), .LANE_W(LW), .LANES(LANES)) dut (
        .clk(clk), .reset(reset),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .v_req(v_req), .v_we(v_we), .v_addr(v_addr), .v_wdata(v_wdata),
        .v_rdata(v_rdata), .v_ready(v_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    // Synchronous RAM with one cycle of read latency, plus a log of writes.
    logic [31:0] ram [logic [31:0]];
    logic [63:0] wlog [$];
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] = mem_wdata;
            wlog.push_back({mem_addr, mem_wdata});
        end
        mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : 32'h0;
    end

    // Reference model state.
    logic [31:0]   ref_mem [logic [31:0]];
    logic [63:0]   exp_log [$];
    int            ref_last;
    logic [31:0]   ref_s_rdata;
    logic [VW-1:0] ref_v_rdata;
    int            n_pass = 0;
    int            n_total = 0;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic int exp_lat(input bit isv, input bit we);
        if (isv) return we ? LANES + 1 : LANES + 2;
        return we ? 2 : 3;
    endfunction

    function automatic void model_scalar(input bit we, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] a = addr & ~32'h3;
        if (we) ref_mem[a] = wd;
        else    ref_s_rdata = ref_rd(a);
        ref_last = 0;
    endfunction

    function automatic void model_vector(input bit we, input logic [31:0] base, input logic [VW-1:0] wd);
        for (int i = 0; i < LANES; i++) begin
            logic [31:0] a = (base & ~32'h3) + 32'(4 * i);
            if (we) ref_mem[a] = wd[LW*i +: LW];
            else    ref_v_rdata[LW*i +: LW] = ref_rd(a);
        end
        ref_last = 1;
    endfunction

    function automatic void exp_log_build(input bit isv, input bit we, input logic [31:0] addr, input logic [VW-1:0] wd);
        exp_log.delete();
        if (we) begin
            if (!isv) exp_log.push_back({addr & ~32'h3, wd[31:0]});
            else for (int i = 0; i < LANES; i++)
                exp_log.push_back({(addr & ~32'h3) + 32'(4 * i), wd[LW*i +: LW]});
        end
    endfunction

    function automatic int log_mismatch();
        int n = 0;
        if (wlog.size() != exp_log.size()) return -1;
        foreach (exp_log[i]) if (wlog[i] !== exp_log[i]) n++;
        return n;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[LW*i +: LW] = $urandom;
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        s_req = 0; s_we = 0; s_addr = 0; s_wdata = 0;
        v_req = 0; v_we = 0; v_addr = 0; v_wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        ref_last = 1; ref_s_rdata = '0; ref_v_rdata = '0;
    endtask

    task automatic run_scalar(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                              output int lat, output bit stall_ok);
        wlog.delete();
        @(negedge clk);
        s_req = 1; s_we = we; s_addr = addr; s_wdata = wd;
        lat = 0; stall_ok = 1;
        do begin
            @(negedge clk);
            lat++;
            if (s_ready == stall) stall_ok = 0;
            if (!s_ready) begin
                s_we = 1'($urandom); s_addr = $urandom; s_wdata = $urandom;
            end
        end while (!s_ready && lat < 40);
        s_req = 0;
    endtask

    task automatic run_vector(input bit we, input logic [31:0] base, input logic [VW-1:0] wd,
                              output int lat, output bit stall_ok);
        wlog.delete();
        @(negedge clk);
        v_req = 1; v_we = we; v_addr = base; v_wdata = wd;
        lat = 0; stall_ok = 1;
        do begin
            @(negedge clk);
            lat++;
            if (v_ready == stall) stall_ok = 0;
            if (!v_ready) begin
                v_we = 1'($urandom); v_addr = $urandom; v_wdata = rand_vec();
            end
        end while (!v_ready && lat < 40);
        v_req = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({s_ready, v_ready, mem_we, stall} !== 4'b0) $display("FAIL reset_ctrl got %b want 0000", {s_ready, v_ready, mem_we, stall});
        else n_pass++;
        n_total++;
        if ({mem_addr, mem_wdata} !== 64'h0) $display("FAIL reset_port got %h want 0", {mem_addr, mem_wdata});
        else n_pass++;
        n_total++;
        if ({s_rdata, v_rdata} !== '0) $display("FAIL reset_rdata got %h want 0", {s_rdata, v_rdata});
        else n_pass++;
    endtask

    task automatic test_scalar();
        int lat; bit sok; int lm;
        run_scalar(1, 32'h10, 32'hDEADBEEF, lat, sok);
        model_scalar(1, 32'h10, 32'hDEADBEEF);
        n_total++;
        if (lat !== 2) $display("FAIL s_wr_latency got %0d want 2", lat); else n_pass++;
        n_total++;
        if (wlog.size() !== 1 || wlog[0] !== {32'h10, 32'hDEADBEEF})
            $display("FAIL s_wr_port got size %0d entry %h want 1 entry 00000010deadbeef", wlog.size(), wlog.size() ? wlog[0] : 64'h0);
        else n_pass++;
        n_total++;
        if (!sok) $display("FAIL s_wr_stall got bad stall want high until ready"); else n_pass++;
        run_scalar(0, 32'h10, $urandom, lat, sok);
        model_scalar(0, 32'h10, 32'h0);
        n_total++;
        if (lat !== 3) $display("FAIL s_rd_latency got %0d want 3", lat); else n_pass++;
        n_total++;
        if (s_rdata !== ref_s_rdata) $display("FAIL s_rd_data got %h want %h", s_rdata, ref_s_rdata); else n_pass++;
        lm = log_mismatch();
        exp_log.delete();
        lm = log_mismatch();
        n_total++;
        if (lm != 0) $display("FAIL s_rd_nowrite got %0d writes want 0", wlog.size()); else n_pass++;
    endtask

    task automatic test_vector();
        int lat; bit sok; int lm;
        logic [VW-1:0] wd;
        for (int i = 0; i < LANES; i++) wd[LW*i +: LW] = 32'h1000 + 32'(i);
        run_vector(1, 32'h100, wd, lat, sok);
        exp_log_build(1, 1, 32'h100, wd);
        model_vector(1, 32'h100, wd);
        lm = log_mismatch();
        n_total++;
        if (lat !== 9) $display("FAIL v_wr_latency got %0d want 9", lat); else n_pass++;
        n_total++;
        if (lm != 0) $display("FAIL v_wr_beats got %0d bad (size %0d) want 0", lm, wlog.size()); else n_pass++;
        n_total++;
        if (!sok || v_rdata !== ref_v_rdata) $display("FAIL v_wr_stall_hold got stall_ok=%0d v_rdata=%h want 1 %h", sok, v_rdata, ref_v_rdata);
        else n_pass++;
        run_vector(0, 32'h100, rand_vec(), lat, sok);
        model_vector(0, 32'h100, '0);
        n_total++;
        if (lat !== 10) $display("FAIL v_rd_latency got %0d want 10", lat); else n_pass++;
        n_total++;
        if (v_rdata !== ref_v_rdata) $display("FAIL v_rd_data got %h want %h", v_rdata, ref_v_rdata); else n_pass++;
    endtask

    task automatic test_arbitration();
        int kind [4]; int pos [4]; int k = 0; int cyc = 0; int stall_bad = 0;
        int e_kind; int prev = -1; int e_pos;
        logic [VW-1:0] vwd = rand_vec();
        logic [31:0] swd = $urandom;
        do_reset();
        foreach (kind[j]) begin kind[j] = -1; pos[j] = -1; end
        @(negedge clk);
        s_req = 1; s_we = 1; s_addr = 32'h40; s_wdata = swd;
        v_req = 1; v_we = 1; v_addr = 32'h500; v_wdata = vwd;
        while (k < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (!stall) stall_bad++;
            if (s_ready) begin kind[k] = 0; pos[k] = cyc; k++; end
            else if (v_ready) begin kind[k] = 1; pos[k] = cyc; k++; end
        end
        s_req = 0; v_req = 0;
        n_total++;
        if (stall_bad != 0) $display("FAIL arb_stall got %0d low cycles want 0", stall_bad); else n_pass++;
        for (int j = 0; j < 4; j++) begin
            e_kind = (ref_last == 1) ? 0 : 1;
            e_pos = prev + 1 + exp_lat(e_kind[0], 1);
            n_total++;
            if (kind[j] != e_kind || pos[j] != e_pos)
                $display("FAIL arb_grant%0d got kind %0d cycle %0d want kind %0d cycle %0d", j, kind[j], pos[j], e_kind, e_pos);
            else n_pass++;
            if (e_kind == 0) model_scalar(1, 32'h40, swd);
            else model_vector(1, 32'h500, vwd);
            prev = e_pos;
        end
    endtask

    task automatic test_wrap();
        int lat; bit sok; int lm;
        logic [VW-1:0] wd = rand_vec();
        logic [31:0] sd = $urandom;
        run_vector(1, 32'hFFFF_FFF8, wd, lat, sok);
        exp_log_build(1, 1, 32'hFFFF_FFF8, wd);
        model_vector(1, 32'hFFFF_FFF8, wd);
        lm = log_mismatch();
        n_total++;
        if (lm != 0 || lat !== 9) $display("FAIL wrap_beats got %0d bad lat %0d want 0 lat 9", lm, lat); else n_pass++;
        run_scalar(1, 32'h13, sd, lat, sok);
        model_scalar(1, 32'h13, sd);
        n_total++;
        if (wlog.size() !== 1 || wlog[0] !== {32'h10, sd})
            $display("FAIL misaligned_addr got size %0d entry %h want %h", wlog.size(), wlog.size() ? wlog[0] : 64'h0, {32'h10, sd});
        else n_pass++;
        run_vector(0, 32'hFFFF_FFFA, '0, lat, sok);
        model_vector(0, 32'hFFFF_FFFA, '0);
        n_total++;
        if (v_rdata !== ref_v_rdata) $display("FAIL wrap_read got %h want %h", v_rdata, ref_v_rdata); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int lat; bit sok; int lm;
        logic [VW-1:0] wd = rand_vec();
        wlog.delete();
        @(negedge clk);
        v_req = 1; v_we = 1; v_addr = 32'h200; v_wdata = wd;
        repeat (4) @(negedge clk);
        n_total++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h20C, wd[LW*3 +: LW]})
            $display("FAIL beat3_port got %h want %h", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h20C, wd[LW*3 +: LW]});
        else n_pass++;
        reset = 1; v_req = 0;
        @(negedge clk);
        n_total++;
        if ({mem_we, mem_addr, mem_wdata, s_ready, v_ready, stall} !== '0 || {s_rdata, v_rdata} !== '0)
            $display("FAIL midreset_outputs got %h want 0", {mem_we, mem_addr, mem_wdata, s_ready, v_ready, stall});
        else n_pass++;
        reset = 0;
        ref_last = 1; ref_s_rdata = '0; ref_v_rdata = '0;
        repeat (12) @(negedge clk);
        exp_log.delete();
        for (int i = 0; i < 4; i++) begin
            exp_log.push_back({32'h200 + 32'(4 * i), wd[LW*i +: LW]});
            ref_mem[32'h200 + 32'(4 * i)] = wd[LW*i +: LW];
        end
        lm = log_mismatch();
        n_total++;
        if (lm != 0) $display("FAIL midreset_writes got %0d bad (size %0d) want 4 lanes only", lm, wlog.size()); else n_pass++;
        run_vector(0, 32'h200, '0, lat, sok);
        model_vector(0, 32'h200, '0);
        n_total++;
        if (v_rdata !== ref_v_rdata) $display("FAIL midreset_readback got %h want %h", v_rdata, ref_v_rdata); else n_pass++;
    endtask

    task automatic test_hold();
        int lat; bit sok;
        logic [VW-1:0] wd = rand_vec();
        run_scalar(0, 32'h10, 32'h0, lat, sok);
        model_scalar(0, 32'h10, 32'h0);
        run_vector(1, 32'h600, wd, lat, sok);
        model_vector(1, 32'h600, wd);
        n_total++;
        if ({s_rdata, v_rdata} !== {ref_s_rdata, ref_v_rdata}) $display("FAIL hold_after_vwrite got %h want %h", {s_rdata, v_rdata}, {ref_s_rdata, ref_v_rdata});
        else n_pass++;
        run_vector(0, 32'h600, '0, lat, sok);
        model_vector(0, 32'h600, '0);
        run_scalar(1, 32'h24, $urandom, lat, sok);
        model_scalar(1, 32'h24, wlog.size() ? wlog[0][31:0] : 32'h0);
        n_total++;
        if ({s_rdata, v_rdata} !== {ref_s_rdata, ref_v_rdata}) $display("FAIL hold_after_swrite got %h want %h", {s_rdata, v_rdata}, {ref_s_rdata, ref_v_rdata});
        else n_pass++;
    endtask

    task automatic test_random();
        int lat; bit sok; int lm;
        for (int it = 0; it < 24; it++) begin
            bit isv = 1'($urandom_range(0, 1));
            bit we  = 1'($urandom_range(0, 1));
            logic [31:0] addr = 32'h800 + 32'($urandom_range(0, 63));
            logic [VW-1:0] wd = rand_vec();
            if (isv) run_vector(we, addr, wd, lat, sok);
            else     run_scalar(we, addr, wd[31:0], lat, sok);
            exp_log_build(isv, we, addr, wd);
            if (isv) model_vector(we, addr, wd);
            else     model_scalar(we, addr, wd[31:0]);
            lm = log_mismatch();
            n_total++;
            if (lat != exp_lat(isv, we) || !sok)
                $display("FAIL rand%0d_timing got lat %0d stall_ok %0d want lat %0d stall_ok 1", it, lat, sok, exp_lat(isv, we));
            else n_pass++;
            n_total++;
            if (lm != 0) $display("FAIL rand%0d_writes got %0d bad (size %0d) want 0", it, lm, wlog.size()); else n_pass++;
            n_total++;
            if ({s_rdata, v_rdata} !== {ref_s_rdata, ref_v_rdata})
                $display("FAIL rand%0d_rdata got %h want %h", it, {s_rdata, v_rdata}, {ref_s_rdata, ref_v_rdata});
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scalar();
        test_vector();
        test_arbitration();
        test_wrap();
        test_reset_mid_burst();
        test_hold();
        test_random();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
